spi_slave_mode: RTL and testbench
=================================

SPI_SLAVE_MODE -- requirements
Module: spi_slave_mode

Interface
REQ-001 SHALL have parameter BITS, default 8: word length, legal range 2..32.
REQ-002 SHALL have parameter CPOL, default 0: sck idle level.
REQ-003 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
REQ-004 SHALL have parameter LSB_FIRST, default 0: 0 = MSB first on both lines; 1 = LSB first.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port sck, input, 1 bit: SPI clock, asynchronous to clk.
REQ-008 SHALL have port mosi, input, 1 bit: serial data in, asynchronous.
REQ-009 SHALL have port ssel, input, 1 bit: slave select, active-low, asynchronous.
REQ-010 SHALL have port miso, output, 1 bit: serial data out.
REQ-011 SHALL have port rx_data, output, BITS bits: last complete received word.
REQ-012 SHALL have port rx_valid, output, 1 bit: one-cycle pulse, rx_data updated.
REQ-013 SHALL have port tx_data, input, BITS bits: next word to transmit.
REQ-014 SHALL have port tx_valid, input, 1 bit: tx_data offered.
REQ-015 SHALL have port tx_ready, output, 1 bit: transmit holding register empty.
REQ-016 SHALL have port underrun, output, 1 bit: one-cycle pulse, word started with no data loaded.
REQ-017 SHALL have port frame_abort, output, 1 bit: one-cycle pulse, ssel released mid-word.
REQ-018 SHALL have port busy, output, 1 bit: synchronized ssel active.

Function
REQ-019 SHALL synchronize sck, mosi and ssel through two flops each; edges SHALL be detected between the 2nd flop and a 3rd history flop.
REQ-020 SHALL define the leading edge as rising when CPOL=0 and falling when CPOL=1; the trailing edge is the opposite edge.
REQ-021 SHALL ignore sck edges and hold the bit counter at 0 while synchronized ssel is inactive.
REQ-022 SHALL, on each sample edge, shift synchronized mosi into the receive shift register (toward LSB when LSB_FIRST=0, toward MSB when LSB_FIRST=1) and increment a bit counter of width clog2(BITS) that wraps BITS-1 -> 0.
REQ-023 SHALL, on the sample edge taking bit BITS-1, copy the completed word to rx_data and assert rx_valid for exactly one clk in the following cycle; rx_data SHALL hold until the next complete word.
REQ-024 SHALL keep a one-word transmit holding register; tx_ready = holding register empty; a word is accepted when tx_valid && tx_ready, and tx_data is ignored otherwise.
REQ-025 SHALL perform a load event as follows. With CPHA=0: at the synchronized ssel assertion, and at the shift edge following the completion of a word. With CPHA=1: at the first shift edge of each word (bit counter 0).
REQ-026 SHALL, on a load event, move the holding register into the transmit shift register and mark it empty; if it is empty, the block SHALL load all zeros and pulse underrun for one clk.
REQ-027 SHALL, on a shift edge that is not a load event, shift the transmit register by one bit (direction per LSB_FIRST, zero fill).
REQ-028 SHALL drive miso from the MSB of the transmit register (LSB when LSB_FIRST=1) while ssel is active, and drive 0 while inactive.
REQ-029 SHALL, when synchronized ssel deasserts with bit counter != 0, discard the partial word, pulse frame_abort for one clk, and not pulse rx_valid; the holding register contents SHALL be retained.
REQ-030 SHALL, when tx_valid && tx_ready coincides with a load event, load the shift register directly from tx_data, leave the holding register empty, and not pulse underrun.
REQ-031 SHALL function correctly only when each sck high and low phase is at least 4 clk periods; behaviour below that is unspecified.

Reset
REQ-032 SHALL, while rst=1 at a clk edge, clear all synchronizers, counters and shift registers; rx_data=0, rx_valid=0, tx_ready=1, underrun=0, frame_abort=0, busy=0, miso=0.
REQ-033 SHALL abandon any frame in progress when rst asserts mid-frame, without pulsing frame_abort.

Verification
REQ-034 Mode 0, BITS=8, tx 0xA5 preloaded; master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C; exactly one rx_valid pulse.
REQ-035 Mode 3 with LSB_FIRST=1: master sends 0x01 -> first mosi bit sampled is 1; rx_data=0x01; tx 0x80 appears on miso as seven 0s followed by 1.
REQ-036 Two back-to-back words with nothing loaded for the second -> second word's miso is all 0; underrun pulses once; tx_ready stays 1.
REQ-037 ssel released after 5 bits -> frame_abort pulses once; no rx_valid; rx_data unchanged; next full frame is received correctly.
REQ-038 rst pulsed after 3 bits -> all outputs at reset values next cycle; no frame_abort; the following frame decodes correctly.

Source files
------------

// File: rtl/spi_slave_mode.sv
// SPI slave with clk-domain oversampling of sck/mosi/ssel, one-word transmit holding
// register, and pulse outputs for word receive, transmit underrun and aborted frames.
module spi_slave_mode #(
    parameter int BITS      = 8,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int LSB_FIRST = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sck,
    input  logic            mosi,
    input  logic            ssel,
    output logic            miso,
    output logic [BITS-1:0] rx_data,
    output logic            rx_valid,
    input  logic [BITS-1:0] tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic            underrun,
    output logic            frame_abort,
    output logic            busy
);

    localparam int            CW   = $clog2(BITS);
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    logic [2:0]      r_sck_s;
    logic [1:0]      r_mosi_s;
    logic [2:0]      r_sel_s;
    logic [CW-1:0]   r_bit_cnt;
    logic [BITS-1:0] r_rx_shift;
    logic [BITS-1:0] r_rx_data;
    logic [BITS-1:0] r_tx_shift;
    logic [BITS-1:0] r_hold;
    logic            r_hold_full;
    logic            r_rx_valid;
    logic            r_underrun;
    logic            r_abort;

    logic            w_sck_rise;
    logic            w_sck_fall;
    logic            w_lead;
    logic            w_trail;
    logic            w_active;
    logic            w_sel_on;
    logic            w_sel_off;
    logic            w_sample;
    logic            w_shift;
    logic            w_load;
    logic            w_accept;
    logic [BITS-1:0] w_rx_next;

    // ssel is synchronized inverted so that a cleared synchronizer means "not selected"
    assign w_active   = r_sel_s[1];
    assign w_sel_on   = r_sel_s[1] & ~r_sel_s[2];
    assign w_sel_off  = ~r_sel_s[1] & r_sel_s[2];
    assign w_sck_rise = r_sck_s[1] & ~r_sck_s[2];
    assign w_sck_fall = ~r_sck_s[1] & r_sck_s[2];
    assign w_lead     = (CPOL == 0) ? w_sck_rise : w_sck_fall;
    assign w_trail    = (CPOL == 0) ? w_sck_fall : w_sck_rise;
    assign w_sample   = w_active & ((CPHA == 0) ? w_lead : w_trail);
    assign w_shift    = w_active & ((CPHA == 0) ? w_trail : w_lead);
    assign w_load     = (CPHA == 0) ? (w_sel_on | (w_shift & (r_bit_cnt == '0)))
                                    : (w_shift & (r_bit_cnt == '0));
    assign w_accept   = tx_valid & ~r_hold_full;
    assign w_rx_next  = (LSB_FIRST != 0) ? {r_mosi_s[1], r_rx_shift[BITS-1:1]}
                                         : {r_rx_shift[BITS-2:0], r_mosi_s[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            // sck history starts at the idle level so no phantom edge follows reset
            r_sck_s     <= {3{1'(CPOL)}};
            r_mosi_s    <= '0;
            r_sel_s     <= '0;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_tx_shift  <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_sck_s    <= {r_sck_s[1:0], sck};
            r_mosi_s   <= {r_mosi_s[0], mosi};
            r_sel_s    <= {r_sel_s[1:0], ~ssel};
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
            r_abort    <= 1'b0;

            if (!w_active) begin
                r_bit_cnt <= '0;
                if (w_sel_off && (r_bit_cnt != '0))
                    r_abort <= 1'b1;
            end else if (w_sample) begin
                r_rx_shift <= w_rx_next;
                if (r_bit_cnt == LAST) begin
                    r_bit_cnt  <= '0;
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
            end

            // an offer coinciding with a load bypasses the holding register
            if (w_load) begin
                if (w_accept) begin
                    r_tx_shift <= tx_data;
                end else if (r_hold_full) begin
                    r_tx_shift  <= r_hold;
                    r_hold_full <= 1'b0;
                end else begin
                    r_tx_shift <= '0;
                    r_underrun <= 1'b1;
                end
            end else begin
                if (w_shift)
                    r_tx_shift <= (LSB_FIRST != 0) ? (r_tx_shift >> 1) : (r_tx_shift << 1);
                if (w_accept) begin
                    r_hold      <= tx_data;
                    r_hold_full <= 1'b1;
                end
            end
        end
    end

    assign miso        = w_active & ((LSB_FIRST != 0) ? r_tx_shift[0] : r_tx_shift[BITS-1]);
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_ready    = ~r_hold_full;
    assign underrun    = r_underrun;
    assign frame_abort = r_abort;
    assign busy        = w_active;

endmodule

// File: tb/tb_spi_slave_mode.sv
// Bench for spi_slave_mode: a mode-0 MSB-first and a mode-3 LSB-first instance driven by a
// bit-banged master, checked against a word-level model of loads, receives and pulse counts.
module tb_spi_slave_mode;

    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck[2];
    logic       mosi[2];
    logic       ssel[2];
    logic       miso[2];
    logic [7:0] rx_data[2];
    logic       rx_valid[2];
    logic [7:0] tx_data[2];
    logic       tx_valid[2];
    logic       tx_ready[2];
    logic       underrun[2];
    logic       frame_abort[2];
    logic       busy[2];

    always #5 clk = ~clk;

    spi_slave_mode #(.BITS(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0)) u_m0 (
        .clk(clk), .rst(rst), .sck(sck[0]), .mosi(mosi[0]), .ssel(ssel[0]), .miso(miso[0]),
        .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .underrun(underrun[0]), .frame_abort(frame_abort[0]), .busy(busy[0])
    );

    spi_slave_mode #(.BITS(8), .CPOL(1), .CPHA(1), .LSB_FIRST(1)) u_m3 (
        .clk(clk), .rst(rst), .sck(sck[1]), .mosi(mosi[1]), .ssel(ssel[1]), .miso(miso[1]),
        .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .underrun(underrun[1]), .frame_abort(frame_abort[1]), .busy(busy[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    // word-level model state
    bit         hold_full[2];
    logic [7:0] hold_val[2];
    logic [7:0] cur[2];
    logic [7:0] rx_pend[2];
    logic [7:0] rx_held[2];
    int         exp_und[2], exp_abt[2], exp_rxv[2];
    int         obs_und[2], obs_abt[2], obs_rxv[2];
    logic       prv_rxv[2], prv_und[2], prv_abt[2];
    bit         mon_en = 1'b0;
    logic [7:0] mi;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // load event: holding word moves to the shifter, or zeros with an underrun
    task automatic mdl_load(input int d);
        if (hold_full[d]) begin
            cur[d]       = hold_val[d];
            hold_full[d] = 1'b0;
        end else begin
            cur[d] = 8'h00;
            exp_und[d]++;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            for (int d = 0; d < 2; d++) begin
                if (rx_valid[d]) begin
                    chk("rx_data_on_valid", 32'(rx_data[d]), 32'(rx_pend[d]));
                    rx_held[d] = rx_pend[d];
                    obs_rxv[d]++;
                end else begin
                    chk("rx_data_hold", 32'(rx_data[d]), 32'(rx_held[d]));
                end
                if (!busy[d])
                    chk("miso_idle", 32'(miso[d]), 0);
                chk("pulse_width", {29'd0, prv_rxv[d] & rx_valid[d], prv_und[d] & underrun[d],
                                    prv_abt[d] & frame_abort[d]}, 0);
                obs_und[d] += int'(underrun[d]);
                obs_abt[d] += int'(frame_abort[d]);
                prv_rxv[d] = rx_valid[d];
                prv_und[d] = underrun[d];
                prv_abt[d] = frame_abort[d];
            end
        end
    end

    task automatic check_counts(input int d);
        chk("underrun_count", obs_und[d], exp_und[d]);
        chk("abort_count", obs_abt[d], exp_abt[d]);
        chk("rx_valid_count", obs_rxv[d], exp_rxv[d]);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            ssel[d]     = 1'b1;
            tx_valid[d] = 1'b0;
        end
        tick(1);
        for (int d = 0; d < 2; d++) begin
            chk("rst_rx_data", 32'(rx_data[d]), 0);
            chk("rst_rx_valid", 32'(rx_valid[d]), 0);
            chk("rst_tx_ready", 32'(tx_ready[d]), 1);
            chk("rst_underrun", 32'(underrun[d]), 0);
            chk("rst_frame_abort", 32'(frame_abort[d]), 0);
            chk("rst_busy", 32'(busy[d]), 0);
            chk("rst_miso", 32'(miso[d]), 0);
        end
        tick(n - 1);
        for (int d = 0; d < 2; d++) begin
            hold_full[d] = 1'b0;
            rx_pend[d]   = '0;
            rx_held[d]   = '0;
            prv_rxv[d]   = 1'b0;
            prv_und[d]   = 1'b0;
            prv_abt[d]   = 1'b0;
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic push(input int d, input logic [7:0] v);
        int t = 0;
        while (!tx_ready[d] && t < 50) begin
            tick(1);
            t++;
        end
        chk("push_ready", 32'(tx_ready[d]), 1);
        tx_data[d]  = v;
        tx_valid[d] = 1'b1;
        tick(1);
        tx_valid[d]  = 1'b0;
        hold_full[d] = 1'b1;
        hold_val[d]  = v;
        chk("tx_ready_full", 32'(tx_ready[d]), 0);
    endtask

    task automatic start(input int d);
        ssel[d] = 1'b0;
        if (d == 0)
            mdl_load(0);
        tick(H);
        chk("busy_on", 32'(busy[d]), 1);
    endtask

    task automatic stop(input int d);
        tick(H);
        ssel[d] = 1'b1;
        tick(H);
        chk("busy_off", 32'(busy[d]), 0);
    endtask

    task automatic word(input int d, input int nb, input logic [7:0] mo, output logic [7:0] rd);
        int bi;
        rd = '0;
        if (d == 1)
            mdl_load(1);
        for (int i = 0; i < nb; i++) begin
            bi = (d == 1) ? i : 7 - i;
            if (d == 0) begin
                mosi[0] = mo[bi];
                tick(H);
                sck[0] = 1'b1;
                rd[bi] = miso[0];
                if (i == 7) rx_pend[0] = mo;
                tick(H);
                sck[0] = 1'b0;
            end else begin
                sck[1]  = 1'b0;
                mosi[1] = mo[bi];
                tick(H);
                sck[1] = 1'b1;
                rd[bi] = miso[1];
                if (i == 7) rx_pend[1] = mo;
                tick(H);
            end
        end
        if (nb == 8) begin
            chk("miso_word", 32'(rd), 32'(cur[d]));
            exp_rxv[d]++;
            if (d == 0)
                mdl_load(0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        sck[0] = 1'b0;
        sck[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mosi[d] = 1'b0; ssel[d] = 1'b1; tx_data[d] = '0; tx_valid[d] = 1'b0;
            exp_und[d] = 0; exp_abt[d] = 0; exp_rxv[d] = 0;
            obs_und[d] = 0; obs_abt[d] = 0; obs_rxv[d] = 0;
            cur[d] = '0;
        end
        tick(1);
        do_reset(4);
        mon_en = 1'b1;

        // mode 0: preloaded 0xA5 while receiving 0x3C
        push(0, 8'hA5);
        start(0);
        word(0, 8, 8'h3C, mi);
        chk("req034_miso", 32'(mi), 32'h A5);
        chk("req034_rx", 32'(rx_data[0]), 32'h3C);
        stop(0);
        check_counts(0);
        chk("req034_one_valid", obs_rxv[0], 1);

        // mode 0: two words, second queued while the first shifts
        push(0, 8'h11);
        start(0);
        push(0, 8'h22);
        word(0, 8, 8'hC3, mi);
        word(0, 8, 8'h7E, mi);
        chk("two_word_miso2", 32'(mi), 32'h22);
        stop(0);
        check_counts(0);

        // mode 0: abort after 5 bits keeps the holding word; a write while full is ignored
        start(0);
        push(0, 8'h96);
        tx_data[0] = 8'h33; tx_valid[0] = 1'b1;
        tick(1);
        tx_valid[0] = 1'b0;
        word(0, 5, 8'hFF, mi);
        stop(0);
        exp_abt[0]++;
        check_counts(0);
        chk("abort_keeps_hold", 32'(tx_ready[0]), 0);
        chk("abort_rx_unchanged", 32'(rx_data[0]), 32'h7E);
        start(0);
        word(0, 8, 8'h69, mi);
        chk("after_abort_miso", 32'(mi), 32'h96);
        chk("after_abort_rx", 32'(rx_data[0]), 32'h69);
        stop(0);
        check_counts(0);

        // mode 0: word offered exactly at the ssel-assertion load goes straight to the shifter
        ssel[0] = 1'b0;
        tick(2);
        tx_data[0] = 8'hE7; tx_valid[0] = 1'b1;
        tick(1);
        tx_valid[0] = 1'b0;
        cur[0] = 8'hE7;
        chk("bypass_ready", 32'(tx_ready[0]), 1);
        tick(H - 3);
        word(0, 8, 8'h5C, mi);
        chk("bypass_miso", 32'(mi), 32'hE7);
        stop(0);
        check_counts(0);

        // mode 3 LSB first: 0x80 out, 0x01 in, then an unloaded second word
        push(1, 8'h80);
        start(1);
        word(1, 8, 8'h01, mi);
        chk("req035_miso", 32'(mi), 32'h80);
        chk("req035_rx", 32'(rx_data[1]), 32'h01);
        word(1, 8, 8'hF0, mi);
        chk("req036_miso_zero", 32'(mi), 0);
        chk("req036_tx_ready", 32'(tx_ready[1]), 1);
        stop(1);
        check_counts(1);
        chk("req036_one_underrun", obs_und[1], 1);

        // reset after 3 bits abandons the frame silently
        push(1, 8'h3A);
        start(1);
        word(1, 3, 8'h5F, mi);
        do_reset(4);
        check_counts(0);
        check_counts(1);
        push(1, 8'hC5);
        start(1);
        word(1, 8, 8'h9B, mi);
        chk("after_rst_miso", 32'(mi), 32'hC5);
        chk("after_rst_rx", 32'(rx_data[1]), 32'h9B);
        stop(1);
        check_counts(1);
        check_counts(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
